// File: rtl/logic_unit_pipe_pkg.sv
// ============================================================================
// Module      : logic_unit_pipe_pkg
// Description : Shared definitions for the logic unit. Holds the 3-bit opcode
//               map and the output-register state encodings. Both the
//               combinational core and the pipelined top import it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package logic_unit_pipe_pkg;

    // Opcode map. All operations are bitwise over the operand width.
    localparam logic [2:0] OP_NOT  = 3'b000;  // ~x
    localparam logic [2:0] OP_AND  = 3'b001;  // x & y
    localparam logic [2:0] OP_NAND = 3'b010;  // ~(x & y)
    localparam logic [2:0] OP_XOR  = 3'b011;  // x ^ y
    localparam logic [2:0] OP_XNOR = 3'b100;  // ~(x ^ y)
    localparam logic [2:0] OP_OR   = 3'b101;  // x | y
    localparam logic [2:0] OP_NOR  = 3'b110;  // ~(x | y)
    localparam logic [2:0] OP_RSVD = 3'b111;  // reserved, yields all-zeros

    // Output register occupancy.
    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/logic_unit_core.sv
// ============================================================================
// Module      : logic_unit_core
// Description : Purely combinational bitwise operation decoder. Produces the
//               result plus its zero and parity (XOR-reduction) flags.
// Ports       : i_x, i_y  - WIDTH-bit operands
//               i_op      - 3-bit operation select
//               o_result  - WIDTH-bit result
//               o_zero    - result == 0
//               o_parity  - XOR-reduction of result
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module logic_unit_core
    import logic_unit_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  logic [2:0]       i_op,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero,
    output logic             o_parity
);

    logic [WIDTH-1:0] w_res;

    always_comb begin
        w_res = '0;
        case (i_op)
            OP_NOT:  w_res = ~i_x;
            OP_AND:  w_res = i_x & i_y;
            OP_NAND: w_res = ~(i_x & i_y);
            OP_XOR:  w_res = i_x ^ i_y;
            OP_XNOR: w_res = ~(i_x ^ i_y);
            OP_OR:   w_res = i_x | i_y;
            OP_NOR:  w_res = ~(i_x | i_y);
            OP_RSVD: w_res = '0;
            default: w_res = '0;
        endcase
    end

    assign o_result = w_res;
    assign o_zero   = (w_res == '0);
    assign o_parity = ^w_res;

endmodule

`default_nettype wire

// File: rtl/logic_unit_pipe.sv
// ============================================================================
// Module      : logic_unit_pipe
// Description : Registered bitwise logic unit with a single-entry output
//               register and valid/ready handshake on both sides. Reports
//               registered zero/parity flags and counts accepted operations.
//               Optional macro LOGIC_UNIT_ACC_EN adds an accumulator that
//               captures every result and can replace operand y (acc_sel=1).
// Ports       : clk, reset          - clock, synchronous active-high reset
//               in_valid/in_ready   - input handshake
//               x, y, op, acc_sel   - operands, opcode, accumulator select
//               out_valid/out_ready - output handshake
//               w, zero, parity     - registered result and flags
//               op_count            - accepted operations, mod 2^CNT_W
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module logic_unit_pipe
    import logic_unit_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [2:0]       op,
    input  logic             acc_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] w,
    output logic             zero,
    output logic             parity,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic             w_accept;
    logic [WIDTH-1:0] w_opb;
    logic [WIDTH-1:0] w_core_res;
    logic             w_core_zero;
    logic             w_core_parity;
    logic [WIDTH-1:0] r_w;
    logic             r_zero;
    logic             r_parity;
    logic [CNT_W-1:0] r_count;

    // A full register can still take new data on the same edge it drains.
    assign out_valid = (r_state == S_FULL);
    assign in_ready  = !out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;

`ifdef LOGIC_UNIT_ACC_EN
    logic [WIDTH-1:0] r_acc;

    assign w_opb = acc_sel ? r_acc : y;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
        end else if (w_accept) begin
            r_acc <= w_core_res;
        end
    end
`else
    // Accumulator absent: acc_sel has no function and is only sunk here.
    logic w_unused_acc_sel;
    assign w_unused_acc_sel = acc_sel;
    assign w_opb            = y;
`endif

    logic_unit_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_x      (x),
        .i_y      (w_opb),
        .i_op     (op),
        .o_result (w_core_res),
        .o_zero   (w_core_zero),
        .o_parity (w_core_parity)
    );

    // Output register occupancy FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_EMPTY: if (w_accept) w_state_next = S_FULL;
            S_FULL:  if (out_ready && !in_valid) w_state_next = S_EMPTY;
            default: w_state_next = S_EMPTY;
        endcase
    end

    // Result, flags and counter only move on an accept, so an undefined
    // opcode presented with in_valid low never reaches a register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_w      <= '0;
            r_zero   <= 1'b1;
            r_parity <= 1'b0;
            r_count  <= '0;
        end else if (w_accept) begin
            r_w      <= w_core_res;
            r_zero   <= w_core_zero;
            r_parity <= w_core_parity;
            r_count  <= r_count + c_cnt_one;
        end
    end

    assign w        = r_w;
    assign zero     = r_zero;
    assign parity   = r_parity;
    assign op_count = r_count;

endmodule

`default_nettype wire
